adc_voltmeter: RTL and testbench

Downstream consumer of the XADC wrapper's 16-bit conversion word (VAUX6 channel, unipolar, 0–1 V full scale). Averages a power-of-two window of samples and scales the mean to millivolts. Converts the result to four packed BCD digits with a sequential double-dabble for the display driver. Runs on the 100 MHz system clock in the same domain as the XADC DRP interface.

---
 rtl/adc_voltmeter.sv | 84 ++++++++
 tb/tb_adc_voltmeter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/adc_voltmeter.sv
// adc_voltmeter: averages 2^AVG_LOG2 XADC codes, scales the mean to millivolts
// and converts it to packed BCD with a sequential double-dabble.
module adc_voltmeter #(
    parameter int AVG_LOG2 = 8,
    parameter int FULL_SCALE_MV = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data,
    input  logic        sample_valid,
    output logic [13:0] millivolts,
    output logic [15:0] bcd,
    output logic        result_valid,
    output logic        busy,
    output logic        overrun
);
    localparam int CW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
    localparam int SW = 12 + AVG_LOG2;
    typedef enum logic [1:0] {ACCUM, SCALE, CONVERT} state_t;
    state_t state;
    logic [SW-1:0] acc, sum_q, win_sum;
    logic [CW-1:0] count;
    logic [25:0] product;
    logic [13:0] mv, mv_sh;
    logic [15:0] work, adj, next_work;
    logic [3:0] iter;
    logic done, unused_bits;
    assign win_sum = acc + SW'(data[15:4]);
    assign done = sample_valid && count == CW'((1 << AVG_LOG2) - 1);
    assign mv = product[25:12];
    assign mv_sh = mv << iter;
    assign next_work = {adj[14:0], mv_sh[13]};
    assign unused_bits = ^{data[3:0], product[11:0], sum_q, adj[15], mv_sh[12:0]};
    for (genvar g = 0; g < 4; g++) begin : g_dabble
        assign adj[4*g +: 4] = work[4*g +: 4] >= 4'd5 ? work[4*g +: 4] + 4'd3 : work[4*g +: 4];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            count <= '0;
            sum_q <= '0;
            product <= '0;
            work <= '0;
            iter <= '0;
            state <= ACCUM;
            millivolts <= '0;
            bcd <= '0;
            result_valid <= 1'b0;
            busy <= 1'b0;
            overrun <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            overrun <= done && state != ACCUM;
            if (sample_valid) begin
                acc <= done ? '0 : win_sum;
                count <= done ? '0 : count + CW'(1);
            end
            case (state)
                ACCUM: if (done) begin
                    sum_q <= win_sum;
                    busy <= 1'b1;
                    state <= SCALE;
                end
                SCALE: begin
                    product <= 26'(sum_q[AVG_LOG2 +: 12]) * 26'(FULL_SCALE_MV);
                    work <= '0;
                    iter <= '0;
                    state <= CONVERT;
                end
                default: begin
                    work <= next_work;
                    iter <= iter + 4'd1;
                    if (iter == 4'd13) begin
                        millivolts <= mv;
                        bcd <= next_work;
                        result_valid <= 1'b1;
                        busy <= 1'b0;
                        state <= ACCUM;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adc_voltmeter.sv
// tb_adc_voltmeter: two configurations (N=4 @1000 mV, N=1 @3300 mV) checked every
// cycle against an event-time model, plus literal pins on known windows.
module tb_adc_voltmeter;
    localparam int LG [2] = '{2, 0};
    localparam int FS [2] = '{1000, 3300};
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [15:0] data_a = '0, data_b = '0;
    logic sv_a = 1'b0, sv_b = 1'b0;
    logic [13:0] mv_a, mv_b;
    logic [15:0] bcd_a, bcd_b;
    logic rv_a, rv_b, busy_a, busy_b, ov_a, ov_b;
    logic stim_done = 1'b0;
    int errors = 0, checks = 0, cyc = 0;
    int pin_id [2] = '{0, 0};
    int pin_mv [2];
    int pin_bcd [2];
    int pin_seen [2] = '{0, 0};
    int cnt [2] = '{0, 0};
    longint sum [2] = '{0, 0};
    int due [2] = '{-1, -1};
    int ov_at [2] = '{-1, -1};
    int pend_mv [2] = '{0, 0};
    int exp_mv [2] = '{0, 0};
    bit armed = 1'b0;

    always #5 clk = ~clk;

    adc_voltmeter #(.AVG_LOG2(2), .FULL_SCALE_MV(1000)) dut_a (
        .clk(clk), .reset(reset), .data(data_a), .sample_valid(sv_a),
        .millivolts(mv_a), .bcd(bcd_a), .result_valid(rv_a), .busy(busy_a), .overrun(ov_a));
    adc_voltmeter #(.AVG_LOG2(0), .FULL_SCALE_MV(3300)) dut_b (
        .clk(clk), .reset(reset), .data(data_b), .sample_valid(sv_b),
        .millivolts(mv_b), .bcd(bcd_b), .result_valid(rv_b), .busy(busy_b), .overrun(ov_b));

    function automatic int to_bcd(input int m);
        return ((m / 1000) << 12) | ((m / 100 % 10) << 8) | ((m / 10 % 10) << 4) | (m % 10);
    endfunction

    function void check(input string nm, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d got=%0d expected=%0d", nm, d, cyc, act, exp);
        end
    endfunction

    // Model: outputs of cycle c are checked first, then the inputs sampled at the end of c are applied.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int am, ab, ar, abz, ao, dt;
            bit sv;
            am = d == 0 ? int'(mv_a) : int'(mv_b);
            ab = d == 0 ? int'(bcd_a) : int'(bcd_b);
            ar = d == 0 ? int'(rv_a) : int'(rv_b);
            abz = d == 0 ? int'(busy_a) : int'(busy_b);
            ao = d == 0 ? int'(ov_a) : int'(ov_b);
            sv = d == 0 ? sv_a : sv_b;
            dt = d == 0 ? int'(data_a) : int'(data_b);
            if (armed) begin
                if (due[d] == cyc) exp_mv[d] = pend_mv[d];
                check("millivolts", d, am, exp_mv[d]);
                check("bcd", d, ab, to_bcd(exp_mv[d]));
                check("result_valid", d, ar, int'(due[d] == cyc));
                check("busy", d, abz, int'(due[d] > cyc));
                check("overrun", d, ao, int'(ov_at[d] == cyc));
                if (due[d] == cyc && pin_id[d] != pin_seen[d]) begin
                    check("pin_model_mv", d, exp_mv[d], pin_mv[d]);
                    check("pin_bcd", d, ab, pin_bcd[d]);
                    pin_seen[d] = pin_id[d];
                end
            end
            if (due[d] == cyc) due[d] = -1;
            if (reset) begin
                cnt[d] = 0; sum[d] = 0; due[d] = -1; ov_at[d] = -1; exp_mv[d] = 0;
            end else if (sv) begin
                sum[d] += longint'(dt >> 4);
                cnt[d]++;
                if (cnt[d] == (1 << LG[d])) begin
                    if (due[d] >= 0) ov_at[d] = cyc + 1;
                    else begin
                        due[d] = cyc + 16;
                        pend_mv[d] = int'(((sum[d] >> LG[d]) * longint'(FS[d])) >> 12);
                    end
                    cnt[d] = 0;
                    sum[d] = 0;
                end
            end
        end
        if (reset) armed = 1'b1;
        cyc++;
        if (stim_done) begin
            for (int d = 0; d < 2; d++) check("pins_used", d, pin_seen[d], pin_id[d]);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input int n);
        repeat (n) tick();
    endtask
    task automatic sa(input logic [15:0] d);
        data_a = d; sv_a = 1'b1; tick(); sv_a = 1'b0;
    endtask
    task automatic sb(input logic [15:0] d);
        data_b = d; sv_b = 1'b1; tick(); sv_b = 1'b0;
    endtask
    task automatic pin(input int d, input int m, input int b);
        pin_mv[d] = m; pin_bcd[d] = b; pin_id[d]++;
    endtask

    initial begin
        idle(3);
        reset = 1'b0;
        idle(5);
        pin(0, 500, 16'h0500);
        repeat (4) begin sa(16'h8000); idle(99); end
        pin(0, 24, 16'h0024);
        for (int c = 100; c < 104; c++) begin sa({12'(c), 4'hF}); idle(19); end
        pin(0, 999, 16'h0999);
        repeat (4) begin sa(16'hFFFF); idle(3); end
        idle(20);
        pin(1, 3299, 16'h3299);
        sb(16'hFFFF);
        idle(20);
        pin(1, 3299, 16'h3299);
        data_b = 16'hFFFF; sv_b = 1'b1; tick();
        data_b = 16'h0000; tick(); tick();
        sv_b = 1'b0;
        idle(30);
        repeat (3) begin sa(16'h1230); idle(2); end
        sa(16'h1230);
        idle(4);
        reset = 1'b1; tick(); reset = 1'b0;
        idle(30);
        pin(0, 250, 16'h0250);
        repeat (4) sa(16'h4000);
        idle(20);
        sa(16'hFFFF); sa(16'hFFFF);
        reset = 1'b1; idle(3); reset = 1'b0;
        pin(0, 250, 16'h0250);
        repeat (4) begin sa(16'h4000); idle(1); end
        idle(20);
        repeat (3000) begin
            sv_a = $urandom_range(0, 2) == 0;
            data_a = 16'($urandom);
            sv_b = $urandom_range(0, 5) == 0;
            data_b = 16'($urandom);
            reset = $urandom_range(0, 999) == 0;
            tick();
        end
        sv_a = 1'b0; sv_b = 1'b0; reset = 1'b0;
        idle(40);
        stim_done = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not reach its summary in time");
        $fatal(1);
    end
endmodule
